// File: rtl/adder_sum_buffer.sv
// Result FIFO behind the adder: buffers WIDTH+1-bit sums, drops on full with a sticky flag.
// Define ADDER_SUM_BUFFER_STATS_EN to add drop_cnt and max_sum statistics outputs.
module adder_sum_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH:0]           in_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH:0]           out_sum,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef ADDER_SUM_BUFFER_STATS_EN
    ,
    output logic [15:0]              drop_cnt,
    output logic [WIDTH:0]           max_sum
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, drop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign out_sum   = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never cleared; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= in_sum;
    end

`ifdef ADDER_SUM_BUFFER_STATS_EN
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic [WIDTH:0] max_sum_q, max_sum_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        max_sum_d  = max_sum_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        if (push && in_sum > max_sum_q)     max_sum_d  = in_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            max_sum_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            max_sum_q  <= max_sum_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign max_sum  = max_sum_q;
`endif

endmodule

// File: tb/tb_adder_sum_buffer.sv
// Directed bench for adder_sum_buffer (WIDTH=16, DEPTH=8) with immediate-assertion checks.
module tb_adder_sum_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [16:0] in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef ADDER_SUM_BUFFER_STATS_EN
    logic [15:0] drop_cnt;
    logic [16:0] max_sum;
`endif

    int checks = 0;
    int errors = 0;

    adder_sum_buffer #(.WIDTH(16), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef ADDER_SUM_BUFFER_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .max_sum   (max_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [16:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [16:0] fill_vals [8];
        int nrd;

        rst = 1'b1; in_valid = 1'b1; in_sum = 17'h1234; out_ready = 1'b0;

        // Reset held two cycles with in_valid high
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_empty",     32'(empty), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow",  32'(overflow), 32'd0);
        chk("rst_full",      32'(full), 32'd0);
        step();
        chk("rst_nothing_stored", 32'(empty), 32'd1);

        // Single pass
        push_one(17'h0_0005);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sum",   32'(out_sum), 32'h5);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_drained", 32'(empty), 32'd1);

        // Fill and order
        fill_vals[0] = 17'h1_FFFE;
        for (int i = 1; i < 8; i++) fill_vals[i] = 17'(i);
        for (int i = 0; i < 8; i++) push_one(fill_vals[i]);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_order_valid", 32'(out_valid), 32'd1);
            chk("fill_order_sum",   32'(out_sum), 32'(fill_vals[i]));
            step();
        end
        out_ready = 1'b0;
        chk("fill_empty_after", 32'(empty), 32'd1);

        // Overflow
        for (int i = 0; i < 8; i++) push_one(17'(32'h10 + i));
        chk("ovf_full_before", 32'(full), 32'd1);
        chk("ovf_flag_before", 32'(overflow), 32'd0);
        push_one(17'h0_00AA);
        chk("ovf_count",    32'(count), 32'd8);
        chk("ovf_flag",     32'(overflow), 32'd1);
`ifdef ADDER_SUM_BUFFER_STATS_EN
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_sum", 32'(out_sum), 32'h10 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("ovf_drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky",      32'(overflow), 32'd1);
        step();
        chk("ovf_sticky_idle", 32'(overflow), 32'd1);

        // Full with simultaneous push and pop
        do_reset();
        chk("sp_overflow_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) push_one(17'(32'h20 + i));
        chk("sp_full_before", 32'(full), 32'd1);
        chk("sp_head",        32'(out_sum), 32'h20);
        in_valid = 1'b1; in_sum = 17'h0_0123; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("sp_count",    32'(count), 32'd8);
        chk("sp_full",     32'(full), 32'd1);
        chk("sp_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("sp_drain_sum", 32'(out_sum), 32'h20 + 32'(i));
            step();
        end
        chk("sp_late_entry", 32'(out_sum), 32'h123);
        step();
        out_ready = 1'b0;
        chk("sp_empty", 32'(empty), 32'd1);

        // Wrap: push on even cycles, out_ready toggles every cycle
        do_reset();
        nrd = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid  = (c % 2 == 0);
            in_sum    = 17'(c / 2);
            out_ready = (c % 2 == 1);
            if (out_valid && out_ready) begin
                chk("wrap_order", 32'(out_sum), 32'(nrd));
                nrd++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("wrap_delivered", 32'(nrd), 32'd20);
        chk("wrap_empty",     32'(empty), 32'd1);

        // Reset mid-stream with three entries stored
        push_one(17'h7); push_one(17'h8); push_one(17'h9);
        chk("mid_count3", 32'(count), 32'd3);
`ifdef ADDER_SUM_BUFFER_STATS_EN
        chk("mid_max_sum", 32'(max_sum), 32'h13);
`endif
        do_reset();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
`ifdef ADDER_SUM_BUFFER_STATS_EN
        chk("mid_rst_max_sum", 32'(max_sum), 32'd0);
`endif
        push_one(17'h0_0042);
        chk("mid_next_valid", 32'(out_valid), 32'd1);
        chk("mid_next_sum",   32'(out_sum), 32'h42);
        chk("mid_next_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
